bch_stream_encoder: RTL

- Parametrised systematic binary BCH(N,K) encoder with valid/ready handshakes on input and output.
- Processes P message bits per clock using an unrolled LFSR, replacing the fixed 255/191 bit-serial encoder.
- Sits between the message source and the channel/modulator path.
- The generator polynomial, code length and parallelism are all parameters.

---
 rtl/bch_stream_encoder_if.sv | 29 ++
 rtl/bch_stream_encoder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bch_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : bch_stream_encoder_if
// Brief    : Message/codeword handshake bundle for bch_stream_encoder.
// Revision : 1.0
// ============================================================================
interface bch_stream_encoder_if #(
  parameter int K = 191,
  parameter int W = 255
) ();
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] msg;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] codeword;
  logic         busy;

  modport master (
    output in_valid, msg, out_ready,
    input  in_ready, out_valid, codeword, busy
  );

  modport slave (
    input  in_valid, msg, out_ready,
    output in_ready, out_valid, codeword, busy
  );
endinterface
`default_nettype wire

// File: rtl/bch_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bch_stream_encoder
// Brief    : Systematic BCH(N,K) encoder, P message bits per clock through an
//            unrolled LFSR. BCH_EXTENDED_PARITY_EN appends an overall parity bit.
// Revision : 1.0
// ============================================================================
module bch_stream_encoder #(
  parameter int          N        = 255,
  parameter int          K        = 191,
  parameter logic [63:0] GEN_POLY = 64'h6CE707E26B6F9977,
  parameter int          P        = 1
) (
  input wire                  clk,
  input wire                  rst,
  bch_stream_encoder_if.slave bus
);

  localparam int c_r     = N - K;
  localparam int c_steps = K / P;
  localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
`ifdef BCH_EXTENDED_PARITY_EN
  localparam int c_cw_w  = N + 1;
`else
  localparam int c_cw_w  = N;
`endif
  localparam logic [c_r-1:0]     c_gen  = GEN_POLY[c_r-1:0];
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

  if ((K % P) != 0) begin : g_bad_parallelism
    $error("bch_stream_encoder: K must be a multiple of P");
  end
  if (GEN_POLY[0] != 1'b1) begin : g_bad_poly
    $error("bch_stream_encoder: generator constant term must be 1");
  end
  if ((c_r < 2) || (c_r > 64)) begin : g_bad_parity_width
    $error("bch_stream_encoder: N-K must lie in 2..64");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [K-1:0]        r_msg;
  logic [K-1:0]        r_shift;
  logic [c_r-1:0]      r_lfsr;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cw_w-1:0]   r_codeword;
  logic [c_r-1:0]      w_lfsr_next;
  logic [c_cw_w-1:0]   w_codeword_next;
  logic                w_last;

  assign w_last = (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid)  w_state_next = S_ENCODE;
      S_ENCODE: if (w_last)        w_state_next = S_DONE;
      S_DONE:   if (bus.out_ready) w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  // P division steps chained within one cycle, most significant bit first.
  always_comb begin
    w_lfsr_next = r_lfsr;
    for (int j = 0; j < P; j++) begin
      w_lfsr_next = {w_lfsr_next[c_r-2:0], 1'b0}
                  ^ ({c_r{w_lfsr_next[c_r-1] ^ r_shift[K-1-j]}} & c_gen);
    end
  end

`ifdef BCH_EXTENDED_PARITY_EN
  assign w_codeword_next = {r_msg, w_lfsr_next, ^{r_msg, w_lfsr_next}};
`else
  assign w_codeword_next = {r_msg, w_lfsr_next};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg      <= '0;
      r_shift    <= '0;
      r_lfsr     <= '0;
      r_cnt      <= '0;
      r_codeword <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_msg   <= bus.msg;
            r_shift <= bus.msg;
            r_lfsr  <= '0;
            r_cnt   <= '0;
          end
        end
        S_ENCODE: begin
          r_shift <= r_shift << P;
          r_lfsr  <= w_lfsr_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_codeword <= w_codeword_next;
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst directly so it drops as soon as reset asserts.
  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.codeword  = r_codeword;

endmodule
`default_nettype wire
